// File: rtl/ram_arbiter.sv
// Two-port arbiter in front of a single-port synchronous RAM (1-cycle read latency).
// Fixed A priority, B starvation guard, and per-port lock for atomic read-modify-write.
module ram_arbiter #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_WAIT   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic                  a_lock,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_gnt,
  output logic                  a_rvalid,
  output logic [DATA_WIDTH-1:0] a_rdata,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic                  b_lock,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_gnt,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LOCK_A = 2'd1;
  localparam logic [1:0] LOCK_B = 2'd2;
  localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

  logic [1:0]            state, state_nxt;
  logic [3:0]            wait_cnt;
  logic                  a_win, b_win;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q, a_rdata_q, b_rdata_q;

  always_comb begin
    a_win     = 1'b0;
    b_win     = 1'b0;
    state_nxt = state;
    case (state)
      LOCK_A: begin
        a_win = a_req;
        if (!a_lock) state_nxt = IDLE;
      end
      LOCK_B: begin
        b_win = b_req;
        if (!b_lock) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        if (b_req && wait_cnt == WAIT_MAX) b_win = 1'b1;
        else if (a_req)                    a_win = 1'b1;
        else if (b_req)                    b_win = 1'b1;
        if (a_win && a_lock)      state_nxt = LOCK_A;
        else if (b_win && b_lock) state_nxt = LOCK_B;
      end
    endcase
    // Grants are combinational, so they must also be forced low while reset is held.
    if (!rst_n) begin
      a_win = 1'b0;
      b_win = 1'b0;
    end
  end

  assign a_gnt     = a_win;
  assign b_gnt     = b_win;
  assign ram_we    = (a_win & a_we) | (b_win & b_we);
  assign ram_addr  = a_win ? a_addr  : (b_win ? b_addr  : addr_q);
  assign ram_wdata = a_win ? a_wdata : (b_win ? b_wdata : wdata_q);

  // Read data is passed straight through on the valid cycle and held afterwards.
  assign a_rdata = a_rvalid ? ram_rdata : a_rdata_q;
  assign b_rdata = b_rvalid ? ram_rdata : b_rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wait_cnt  <= 4'd0;
      addr_q    <= '0;
      wdata_q   <= '0;
      a_rvalid  <= 1'b0;
      b_rvalid  <= 1'b0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      state    <= state_nxt;
      addr_q   <= ram_addr;
      wdata_q  <= ram_wdata;
      a_rvalid <= a_win & ~a_we;
      b_rvalid <= b_win & ~b_we;
      if (a_rvalid) a_rdata_q <= ram_rdata;
      if (b_rvalid) b_rdata_q <= ram_rdata;
      if (b_win || !b_req)        wait_cnt <= 4'd0;
      else if (wait_cnt < WAIT_MAX) wait_cnt <= wait_cnt + 4'd1;
    end
  end
endmodule
